// File: rtl/tagger_tag_assembler.sv
// Time-tag assembler: joins converter edge subtimes with a free-running coarse counter and
// queues the tag words in a first-word-fall-through FIFO. Optional macro: TAGGER_ROLLOVER_MARK_EN.
module tagger_tag_assembler #(
  parameter int BITS        = 2,
  parameter int COARSE_BITS = 28,
  parameter int DEPTH_LOG2  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          edge_detected,
  input  logic [BITS-1:0]               subtimes,
  output logic [2+COARSE_BITS+BITS-1:0] out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DEPTH_LOG2:0]           fifo_level,
  output logic [15:0]                   lost_count,
  output logic [COARSE_BITS-1:0]        coarse_now
);

  localparam int W     = 2 + COARSE_BITS + BITS;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  logic [COARSE_BITS-1:0] coarse_q, coarse_d;
  logic                   cap_vld_q, cap_vld_d;
  logic [W-1:0]           cap_word_q, cap_word_d;
  logic [DEPTH_LOG2:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [W-1:0]           hold_q, hold_d;
  logic [15:0]            lost_q, lost_d;
  logic [W-1:0]           mem [DEPTH];

  logic [DEPTH_LOG2:0]    level;
  logic                   full, empty, rd, wr_ok, wr_drop, tag_hit, wf, second_wrap;
`ifdef TAGGER_ROLLOVER_MARK_EN
  logic                   pending_q, pending_d;
  logic                   wrap_evt, flag_done, eff_pend;
`endif

  always_comb begin
    level    = wptr_q - rptr_q;
    full     = (level == FULL_LVL);
    empty    = (level == '0);
    rd       = !empty && out_ready;
    wr_ok    = cap_vld_q && (!full || rd);
    wr_drop  = cap_vld_q && !wr_ok;
    tag_hit  = enable && edge_detected;
    coarse_d = coarse_q + 1'b1;
    wptr_d   = wr_ok ? wptr_q + 1'b1 : wptr_q;
    rptr_d   = rd ? rptr_q + 1'b1 : rptr_q;
    hold_d   = rd ? mem[rptr_q[DEPTH_LOG2-1:0]] : hold_q;
`ifdef TAGGER_ROLLOVER_MARK_EN
    // A flag-carrying word already in flight satisfies the pending wrap only once it lands.
    wrap_evt    = &coarse_q;
    flag_done   = wr_ok && cap_word_q[W-2];
    eff_pend    = pending_q && !flag_done;
    second_wrap = wrap_evt && eff_pend;
    wf          = eff_pend;
    pending_d   = wrap_evt ? 1'b1 : (flag_done ? 1'b0 : pending_q);
    cap_vld_d   = tag_hit || eff_pend;
`else
    second_wrap = 1'b0;
    wf          = 1'b0;
    cap_vld_d   = tag_hit;
`endif
    cap_word_d = tag_hit ? {1'b0, wf, coarse_q, subtimes} : {2'b11, {(W-2){1'b0}}};
    lost_d     = sat_add16(lost_q, {1'b0, wr_drop} + {1'b0, second_wrap});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coarse_q  <= '0;
      cap_vld_q <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      hold_q    <= '0;
      lost_q    <= '0;
`ifdef TAGGER_ROLLOVER_MARK_EN
      pending_q <= 1'b0;
`endif
    end else begin
      coarse_q  <= coarse_d;
      cap_vld_q <= cap_vld_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      hold_q    <= hold_d;
      lost_q    <= lost_d;
`ifdef TAGGER_ROLLOVER_MARK_EN
      pending_q <= pending_d;
`endif
    end
  end

  // Capture word and FIFO storage carry data only; validity lives in cap_vld_q and the pointers.
  always_ff @(posedge clk) begin
    cap_word_q <= cap_word_d;
    if (wr_ok) mem[wptr_q[DEPTH_LOG2-1:0]] <= cap_word_q;
  end

  assign out_valid  = !empty;
  assign out_data   = empty ? hold_q : mem[rptr_q[DEPTH_LOG2-1:0]];
  assign fifo_level = level;
  assign lost_count = lost_q;
  assign coarse_now = coarse_q;

endmodule

// File: tb/tb_tagger_tag_assembler.sv
// Directed bench for tagger_tag_assembler (BITS=2, COARSE_BITS=4, DEPTH_LOG2=2, W=8).
module tb_tagger_tag_assembler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       edge_detected = 1'b0;
  logic [1:0] subtimes = 2'd0;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic [2:0] fifo_level;
  logic [15:0] lost_count;
  logic [3:0] coarse_now;

  int n_asserts = 0;
  int n_fail = 0;

  tagger_tag_assembler #(.BITS(2), .COARSE_BITS(4), .DEPTH_LOG2(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .edge_detected(edge_detected),
    .subtimes(subtimes), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_level(fifo_level), .lost_count(lost_count), .coarse_now(coarse_now)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_lost", 32'(lost_count), 0);
    check("rst_coarse", 32'(coarse_now), 0);
    rst_n = 1'b1;

    // Single tag: edge in cycle coarse=5, subtime=2 -> 0x16 two clocks later
    repeat (5) step();
    check("coarse_5", 32'(coarse_now), 5);
    enable = 1'b1; edge_detected = 1'b1; subtimes = 2'd2; out_ready = 1'b1;
    step();
    edge_detected = 1'b0;
    check("t1_lat1_valid", 32'(out_valid), 0);
    step();
    check("t1_valid", 32'(out_valid), 1);
    check("t1_data", 32'(out_data), 32'h16);
    check("t1_level", 32'(fifo_level), 1);
    step();
    check("t1_drained_level", 32'(fifo_level), 0);
    check("t1_drained_valid", 32'(out_valid), 0);
    check("t1_hold_data", 32'(out_data), 32'h16);

    // Six edges into a stalled depth-4 FIFO (cycles coarse 8..13)
    out_ready = 1'b0;
    edge_detected = 1'b1;
    for (int i = 0; i < 6; i++) begin
      subtimes = 2'(i);
      step();
    end
    // Edge in cycle 14 is written during cycle 15 together with a read
    subtimes = 2'd1;
    step();
    check("t2_level", 32'(fifo_level), 4);
    check("t2_lost", 32'(lost_count), 2);
    check("t2_head", 32'(out_data), 32'h20);
    check("t2_valid", 32'(out_valid), 1);
    edge_detected = 1'b0; out_ready = 1'b1;
    step();
    check("t3_level_full_rw", 32'(fifo_level), 4);
    check("t3_lost_same", 32'(lost_count), 2);
    check("t2_word1", 32'(out_data), 32'h25);
    step();
    check("t2_word2", 32'(out_data), 32'h2A);
    step();
    check("t2_word3", 32'(out_data), 32'h2F);
    step();
    check("t3_written_word", 32'(out_data), 32'h39);
`ifndef TAGGER_ROLLOVER_MARK_EN
    check("t3_level_tail", 32'(fifo_level), 1);
    step();
    check("t3_empty_level", 32'(fifo_level), 0);
    check("t3_empty_valid", 32'(out_valid), 0);
    check("t3_hold", 32'(out_data), 32'h39);
`else
    check("t4a_level_tail", 32'(fifo_level), 2);
    step();
    check("t4a_marker", 32'(out_data), 32'hC0);
    step();
    check("t4a_empty", 32'(fifo_level), 0);
`endif

    // enable=0 ignores edges
    enable = 1'b0; edge_detected = 1'b1; subtimes = 2'd3;
    repeat (2) step();
    edge_detected = 1'b0; enable = 1'b1;
    repeat (2) step();
    check("en0_level", 32'(fifo_level), 0);
    check("en0_valid", 32'(out_valid), 0);

    // Asynchronous reset mid-stream with three words stored
    out_ready = 1'b0; edge_detected = 1'b1;
    repeat (3) step();
    edge_detected = 1'b0;
    step();
    check("t6_pre_level", 32'(fifo_level), 3);
    check("t6_pre_valid", 32'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_valid", 32'(out_valid), 0);
    check("t6_level", 32'(fifo_level), 0);
    check("t6_coarse", 32'(coarse_now), 0);
    check("t6_lost", 32'(lost_count), 0);
    check("t6_data", 32'(out_data), 0);
    step();
    rst_n = 1'b1;

`ifdef TAGGER_ROLLOVER_MARK_EN
    // Marker across an idle wrap, then a tag coincident with the next wrap
    rst_n = 1'b0; step(); rst_n = 1'b1;
    out_ready = 1'b1; enable = 1'b1; edge_detected = 1'b0;
    repeat (16) step();
    check("t4_wrap_coarse", 32'(coarse_now), 0);
    repeat (2) step();
    check("t4_marker", 32'(out_data), 32'hC0);
    check("t4_marker_level", 32'(fifo_level), 1);
    step();
    check("t4_one_marker", 32'(fifo_level), 0);
    repeat (12) step();
    check("t4_no_extra", 32'(fifo_level), 0);
    step();
    edge_detected = 1'b1; subtimes = 2'd3;
    step();
    edge_detected = 1'b0;
    step();
    check("t4_flag_tag", 32'(out_data), 32'h43);
    check("t4_flag_level", 32'(fifo_level), 1);
    repeat (2) step();
    check("t4_no_marker", 32'(fifo_level), 0);

    // Full across wrap: markers dropped until drained, then one marker written
    rst_n = 1'b0; step(); rst_n = 1'b1;
    out_ready = 1'b0; edge_detected = 1'b1; subtimes = 2'd1;
    repeat (4) step();
    edge_detected = 1'b0;
    repeat (16) step();
    check("t5_lost", 32'(lost_count), 3);
    check("t5_level", 32'(fifo_level), 4);
    check("t5_head", 32'(out_data), 32'h01);
    out_ready = 1'b1;
    step();
    check("t5_w1", 32'(out_data), 32'h05);
    check("t5_lost_hold", 32'(lost_count), 3);
    step();
    check("t5_w2", 32'(out_data), 32'h09);
    step();
    check("t5_w3", 32'(out_data), 32'h0D);
    step();
    check("t5_marker", 32'(out_data), 32'hC0);
    step();
    check("t5_empty", 32'(fifo_level), 0);
    check("t5_empty_valid", 32'(out_valid), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
